id_ex_pipe_reg: RTL and testbench

Parametrised ID/EX-style pipeline register bank: carries NCH data channels and a control bundle through STAGES register slices, with a valid bit per slice. It adds global stall, per-slice flush (bubble insertion) and a saturating bubble counter, none of which the original fixed ID/EX latch supports. It sits between decode and execute and is reusable for the EX/MEM and MEM/WB boundaries.

---
 rtl/id_ex_pipe_reg_pkg.sv | 39 +++
 rtl/id_ex_pipe_reg_if.sv | 29 ++
 rtl/id_ex_pipe_reg_slice.sv | 44 ++++
 rtl/id_ex_pipe_reg.sv | 62 ++++++
 tb/tb_id_ex_pipe_reg.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the ID/EX-style pipeline register bank:
// control bundle layout and data channel indices.
package id_ex_pkg;

   localparam int CTRL_W = 9;

   localparam int CB_REGDST   = 0;
   localparam int CB_ALUOP_LO = 1;
   localparam int CB_ALUOP_HI = 2;
   localparam int CB_ALUSRC   = 3;
   localparam int CB_REGWRITE = 4;
   localparam int CB_MEMTOREG = 5;
   localparam int CB_MEMWRITE = 6;
   localparam int CB_ISBRANCH = 7;
   localparam int CB_ISJUMP   = 8;

   localparam int CH_INST = 0;
   localparam int CH_PC   = 1;
   localparam int CH_RS   = 2;
   localparam int CH_RT   = 3;
   localparam int CH_SEXT = 4;

   // Field order mirrors the bit positions above, MSB first.
   typedef struct packed {
      logic       is_jump;
      logic       is_branch;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       reg_dst;
   } ctrl_t;

   function automatic logic [CTRL_W-1:0] ctrl_pack(input ctrl_t c);
      return c;
   endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Upstream/downstream bundle of the pipeline register bank; the
// producer/consumer side uses master, the register bank uses slave.
interface id_ex_pipe_reg_if #(
   parameter int DATA_W = 32,
   parameter int NCH    = 5,
   parameter int CTRL_W = id_ex_pkg::CTRL_W,
   parameter int STAGES = 1,
   parameter int CNT_W  = 16
);
   logic                    stall_i;
   logic [STAGES-1:0]       flush_i;
   logic                    valid_i;
   logic [CTRL_W-1:0]       ctrl_i;
   logic [NCH*DATA_W-1:0]   data_i;
   logic                    valid_o;
   logic [CTRL_W-1:0]       ctrl_o;
   logic [NCH*DATA_W-1:0]   data_o;
   logic [CNT_W-1:0]        bubble_cnt_o;

   modport master (
      output stall_i, flush_i, valid_i, ctrl_i, data_i,
      input  valid_o, ctrl_o, data_o, bubble_cnt_o
   );

   modport slave (
      input  stall_i, flush_i, valid_i, ctrl_i, data_i,
      output valid_o, ctrl_o, data_o, bubble_cnt_o
   );
endinterface

// File: rtl/id_ex_pipe_reg_slice.sv
// One {valid, ctrl, data} register slice with hold (stall) and
// bubble insertion (flush); flush wins over stall for valid/ctrl.
module pipe_slice #(
   parameter int DATA_W = 32,
   parameter int NCH    = 5,
   parameter int CTRL_W = 9
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  i_stall,
   input  logic                  i_flush,
   input  logic                  i_v,
   input  logic [CTRL_W-1:0]     i_ctrl,
   input  logic [NCH*DATA_W-1:0] i_data,
   output logic                  o_v,
   output logic [CTRL_W-1:0]     o_ctrl,
   output logic [NCH*DATA_W-1:0] o_data
);
   logic                  r_v;
   logic [CTRL_W-1:0]     r_ctrl;
   logic [NCH*DATA_W-1:0] r_data;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_v    <= 1'b0;
         r_ctrl <= '0;
         r_data <= '0;
      end else begin
         // Data never sees flush: a killed entry keeps its payload.
         if (!i_stall) r_data <= i_data;
         if (i_flush) begin
            r_v    <= 1'b0;
            r_ctrl <= '0;
         end else if (!i_stall) begin
            r_v    <= i_v;
            r_ctrl <= i_v ? i_ctrl : '0;
         end
      end
   end

   assign o_v    = r_v;
   assign o_ctrl = r_ctrl;
   assign o_data = r_data;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX-style pipeline register bank: STAGES slices in series with stall,
// per-slice flush, masked control output and a saturating bubble counter.
module id_ex_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int NCH    = 5,
   parameter int CTRL_W = id_ex_pkg::CTRL_W,
   parameter int STAGES = 1,
   parameter int CNT_W  = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   id_ex_pipe_reg_if.slave  bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("id_ex_pipe_reg: STAGES must be within 1..4");
   end

   // Index 0 is the upstream input, index k+1 is the output of slice k.
   logic                  w_v    [0:STAGES];
   logic [CTRL_W-1:0]     w_ctrl [0:STAGES];
   logic [NCH*DATA_W-1:0] w_data [0:STAGES];
   logic [CNT_W-1:0]      r_bubble_cnt;

   assign w_v[0]    = bus.valid_i;
   assign w_ctrl[0] = bus.ctrl_i;
   assign w_data[0] = bus.data_i;

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      pipe_slice #(
         .DATA_W (DATA_W),
         .NCH    (NCH),
         .CTRL_W (CTRL_W)
      ) u_slice (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .i_stall (bus.stall_i),
         .i_flush (bus.flush_i[k]),
         .i_v     (w_v[k]),
         .i_ctrl  (w_ctrl[k]),
         .i_data  (w_data[k]),
         .o_v     (w_v[k+1]),
         .o_ctrl  (w_ctrl[k+1]),
         .o_data  (w_data[k+1])
      );
   end

   // Counts on the pre-edge valid of the last slice, same edge as the slices.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_bubble_cnt <= '0;
      end else if (!w_v[STAGES] && (r_bubble_cnt != CNT_MAX)) begin
         r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
   end

   assign bus.valid_o      = w_v[STAGES];
   assign bus.ctrl_o       = w_v[STAGES] ? w_ctrl[STAGES] : '0;
   assign bus.data_o       = w_data[STAGES];
   assign bus.bubble_cnt_o = r_bubble_cnt;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: three instances (STAGES=1 with a 4-bit counter,
// STAGES=2, STAGES=3) driven from a table and hand sequences, scoreboarded.
module tb_id_ex_pipe_reg;
   import id_ex_pkg::*;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_err;

   id_ex_pipe_reg_if #(.STAGES(1), .CNT_W(4))  b1 ();
   id_ex_pipe_reg_if #(.STAGES(2), .CNT_W(16)) b2 ();
   id_ex_pipe_reg_if #(.STAGES(3), .CNT_W(16)) b3 ();

   id_ex_pipe_reg #(.STAGES(1), .CNT_W(4))  u1 (.clk_i(clk), .rst_i(rst), .bus(b1));
   id_ex_pipe_reg #(.STAGES(2), .CNT_W(16)) u2 (.clk_i(clk), .rst_i(rst), .bus(b2));
   id_ex_pipe_reg #(.STAGES(3), .CNT_W(16)) u3 (.clk_i(clk), .rst_i(rst), .bus(b3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int           dut;
      int           due;
      logic         v;
      logic [8:0]   ctrl;
      logic [159:0] data;
   } exp_t;

   typedef struct {
      logic        v;
      logic [8:0]  c;
      logic [31:0] inst;
      logic [31:0] pc;
      logic        ev;
      logic [8:0]  ec;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[6];

   function automatic logic [159:0] mk_data(input logic [31:0] inst, input logic [31:0] pc,
                                            input logic [31:0] rs, input logic [31:0] rt,
                                            input logic [31:0] sx);
      logic [159:0] d;
      d = '0;
      d[CH_INST*32 +: 32] = inst;
      d[CH_PC*32   +: 32] = pc;
      d[CH_RS*32   +: 32] = rs;
      d[CH_RT*32   +: 32] = rt;
      d[CH_SEXT*32 +: 32] = sx;
      return d;
   endfunction

   task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic read_out(input int dut, output logic v, output logic [8:0] c,
                           output logic [159:0] d, output logic [15:0] bc);
      case (dut)
         1: begin v = b1.valid_o; c = b1.ctrl_o; d = b1.data_o; bc = {12'd0, b1.bubble_cnt_o}; end
         2: begin v = b2.valid_o; c = b2.ctrl_o; d = b2.data_o; bc = b2.bubble_cnt_o; end
         default: begin v = b3.valid_o; c = b3.ctrl_o; d = b3.data_o; bc = b3.bubble_cnt_o; end
      endcase
   endtask

   task automatic set_in(input int dut, input logic v, input logic [8:0] c,
                         input logic [159:0] d, input logic st, input logic [2:0] fl);
      case (dut)
         1: begin b1.valid_i = v; b1.ctrl_i = c; b1.data_i = d; b1.stall_i = st; b1.flush_i = fl[0:0]; end
         2: begin b2.valid_i = v; b2.ctrl_i = c; b2.data_i = d; b2.stall_i = st; b2.flush_i = fl[1:0]; end
         default: begin b3.valid_i = v; b3.ctrl_i = c; b3.data_i = d; b3.stall_i = st; b3.flush_i = fl; end
      endcase
   endtask

   task automatic expect_at(input int dut, input int due, input logic v,
                            input logic [8:0] c, input logic [159:0] d);
      exp_t e;
      e.dut = dut; e.due = due; e.v = v; e.ctrl = c; e.data = d;
      sb.push_back(e);
   endtask

   // Drive one entry with no stall/flush and predict it after lat cycles.
   task automatic drv(input int dut, input logic v, input logic [8:0] c,
                      input logic [159:0] d, input int lat);
      set_in(dut, v, c, d, 1'b0, 3'b000);
      expect_at(dut, cyc + lat, v, v ? c : 9'h000, d);
   endtask

   task automatic step();
      logic         v;
      logic [8:0]   c;
      logic [159:0] d;
      logic [15:0]  bc;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due <= cyc) begin
            read_out(sb[i].dut, v, c, d, bc);
            check($sformatf("d%0d@%0d valid_o", sb[i].dut, cyc), {159'd0, v}, {159'd0, sb[i].v});
            check($sformatf("d%0d@%0d ctrl_o", sb[i].dut, cyc), {151'd0, c}, {151'd0, sb[i].ctrl});
            check($sformatf("d%0d@%0d data_o", sb[i].dut, cyc), d, sb[i].data);
            sb.delete(i);
         end
      end
   endtask

   task automatic check_bubble(input int dut, input logic [15:0] exp, input string nm);
      logic         v;
      logic [8:0]   c;
      logic [159:0] d;
      logic [15:0]  bc;
      read_out(dut, v, c, d, bc);
      check(nm, {144'd0, bc}, {144'd0, exp});
   endtask

   task automatic idle_all();
      for (int k = 1; k <= 3; k++) set_in(k, 1'b0, 9'h000, 160'd0, 1'b0, 3'b000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic         v;
      logic [8:0]   c;
      logic [159:0] d;
      logic [15:0]  bc;
      logic [159:0] dA, dB, dC, dD, dP, dE, dF, dX, dY;
      logic [8:0]   cE;
      int           t;

      cyc = 0; n_checks = 0; n_err = 0;
      rst = 1'b1;
      idle_all();
      step();
      step();

      // Reset state of every instance.
      for (int k = 1; k <= 3; k++) begin
         read_out(k, v, c, d, bc);
         check($sformatf("reset d%0d valid_o", k), {159'd0, v}, 160'd0);
         check($sformatf("reset d%0d ctrl_o", k), {151'd0, c}, 160'd0);
         check($sformatf("reset d%0d data_o", k), d, 160'd0);
         check($sformatf("reset d%0d bubble_cnt_o", k), {144'd0, bc}, 160'd0);
      end
      rst = 1'b0;

      // Table-driven single-stage vectors.
      tbl[0] = '{1'b1, 9'h1F0, 32'h8C220004, 32'h0000_0000, 1'b1, 9'h1F0};
      tbl[1] = '{1'b0, 9'h1FF, 32'hDEADBEEF, 32'h0000_0004, 1'b0, 9'h000};
      tbl[2] = '{1'b1, 9'h013, 32'h00221820, 32'h0000_0008, 1'b1, 9'h013};
      tbl[3] = '{1'b1, 9'h100, 32'h08000010, 32'h0000_000C, 1'b1, 9'h100};
      tbl[4] = '{1'b0, 9'h050, 32'h00000000, 32'h0000_0010, 1'b0, 9'h000};
      tbl[5] = '{1'b1, 9'h0D0, 32'hAC220008, 32'h0000_0014, 1'b1, 9'h0D0};
      for (int i = 0; i < 6; i++) begin
         d = mk_data(tbl[i].inst, tbl[i].pc, 32'h1000 + i, 32'h2000 + i, 32'hFFFF_FFF0 + i);
         set_in(1, tbl[i].v, tbl[i].c, d, 1'b0, 3'b000);
         expect_at(1, cyc + 1, tbl[i].ev, tbl[i].ec, d);
         step();
      end
      idle_all();
      step();

      // Bubble counting and saturation on the 4-bit counter.
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_in(1, 1'b0, 9'h1FF, mk_data(32'h1, 32'h2, 32'h3, 32'h4, 32'h5), 1'b0, 3'b000);
      step();
      read_out(1, v, c, d, bc);
      check("bubble ctrl_o masked", {151'd0, c}, 160'd0);
      check_bubble(1, 16'd1, "bubble_cnt after 1");
      step();
      check_bubble(1, 16'd2, "bubble_cnt after 2");
      repeat (12) step();
      check_bubble(1, 16'd14, "bubble_cnt after 14");
      repeat (6) step();
      check_bubble(1, 16'd15, "bubble_cnt saturated");
      idle_all();

      // Three-stage stream: pc 0, 4, 8 back to back.
      expect_at(3, cyc + 1, 1'b0, 9'h000, 160'd0);
      expect_at(3, cyc + 2, 1'b0, 9'h000, 160'd0);
      drv(3, 1'b1, 9'h011, mk_data(32'h20080001, 32'h0, 32'h11, 32'h21, 32'h1), 3); step();
      drv(3, 1'b1, 9'h012, mk_data(32'h20080002, 32'h4, 32'h12, 32'h22, 32'h2), 3); step();
      drv(3, 1'b1, 9'h013, mk_data(32'h20080003, 32'h8, 32'h13, 32'h23, 32'h3), 3); step();
      for (int i = 0; i < 3; i++) begin
         drv(3, 1'b0, 9'h000, 160'd0, 3);
         step();
      end
      idle_all();
      repeat (3) step();

      // Two-stage stream with a two-cycle stall; upstream holds C while stalled.
      dA = mk_data(32'hA0, 32'h100, 32'h1, 32'h2, 32'h3);
      dB = mk_data(32'hB0, 32'h104, 32'h4, 32'h5, 32'h6);
      dC = mk_data(32'hC0, 32'h108, 32'h7, 32'h8, 32'h9);
      dD = mk_data(32'hD0, 32'h10C, 32'hA, 32'hB, 32'hC);
      t = cyc;
      expect_at(2, t + 1, 1'b0, 9'h000, 160'd0);
      expect_at(2, t + 2, 1'b1, 9'h01A, dA);
      expect_at(2, t + 3, 1'b1, 9'h01A, dA);
      expect_at(2, t + 4, 1'b1, 9'h01A, dA);
      expect_at(2, t + 5, 1'b1, 9'h01B, dB);
      expect_at(2, t + 6, 1'b1, 9'h01C, dC);
      expect_at(2, t + 7, 1'b1, 9'h01D, dD);
      expect_at(2, t + 8, 1'b0, 9'h000, 160'd0);
      set_in(2, 1'b1, 9'h01A, dA, 1'b0, 3'b000); step();
      set_in(2, 1'b1, 9'h01B, dB, 1'b0, 3'b000); step();
      set_in(2, 1'b1, 9'h01C, dC, 1'b1, 3'b000); step();
      set_in(2, 1'b1, 9'h01C, dC, 1'b1, 3'b000); step();
      set_in(2, 1'b1, 9'h01C, dC, 1'b0, 3'b000); step();
      set_in(2, 1'b1, 9'h01D, dD, 1'b0, 3'b000); step();
      idle_all();
      repeat (3) step();

      // Flush slice 0 while stalled: RegWrite entry becomes a bubble, slice 1 holds.
      dP = mk_data(32'h1F0, 32'h1F0, 32'h0, 32'h0, 32'h0);
      dE = mk_data(32'h8C220004, 32'h200, 32'h5, 32'h6, 32'h4);
      dF = mk_data(32'hAC220008, 32'h204, 32'h7, 32'h8, 32'h8);
      cE = 9'h000;
      cE[CB_REGWRITE] = 1'b1;
      t = cyc;
      expect_at(2, t + 1, 1'b0, 9'h000, 160'd0);
      expect_at(2, t + 2, 1'b1, 9'h011, dP);
      expect_at(2, t + 3, 1'b1, 9'h011, dP);
      expect_at(2, t + 4, 1'b0, 9'h000, dE);
      expect_at(2, t + 5, 1'b1, 9'h030, dF);
      expect_at(2, t + 6, 1'b0, 9'h000, 160'd0);
      set_in(2, 1'b1, 9'h011, dP, 1'b0, 3'b000); step();
      set_in(2, 1'b1, cE, dE, 1'b0, 3'b000); step();
      set_in(2, 1'b1, 9'h030, dF, 1'b1, 3'b001); step();
      set_in(2, 1'b1, 9'h030, dF, 1'b0, 3'b000); step();
      idle_all();
      repeat (3) step();

      // Reset with three valid entries in flight on the three-stage instance.
      dX = mk_data(32'h0F0F0F0F, 32'h300, 32'h1, 32'h1, 32'h1);
      dY = mk_data(32'h12345678, 32'h400, 32'h2, 32'h2, 32'h2);
      t = cyc;
      expect_at(3, t + 1, 1'b0, 9'h000, 160'd0);
      expect_at(3, t + 2, 1'b0, 9'h000, 160'd0);
      expect_at(3, t + 3, 1'b1, 9'h018, dX);
      set_in(3, 1'b1, 9'h018, dX, 1'b0, 3'b000); step();
      set_in(3, 1'b1, 9'h019, mk_data(32'h1, 32'h304, 32'h0, 32'h0, 32'h0), 1'b0, 3'b000); step();
      set_in(3, 1'b1, 9'h01A, mk_data(32'h2, 32'h308, 32'h0, 32'h0, 32'h0), 1'b0, 3'b000); step();
      rst = 1'b1;
      set_in(3, 1'b1, 9'h01F, mk_data(32'h3, 32'h30C, 32'h0, 32'h0, 32'h0), 1'b0, 3'b000);
      expect_at(3, t + 4, 1'b0, 9'h000, 160'd0);
      step();
      check_bubble(3, 16'd0, "bubble_cnt cleared by reset");
      rst = 1'b0;
      expect_at(3, t + 5, 1'b0, 9'h000, 160'd0);
      expect_at(3, t + 6, 1'b0, 9'h000, 160'd0);
      expect_at(3, t + 7, 1'b1, 9'h011, dY);
      set_in(3, 1'b1, 9'h011, dY, 1'b0, 3'b000);
      step();
      check_bubble(3, 16'd1, "bubble_cnt first post-reset");
      idle_all();
      repeat (4) step();

      foreach (sb[i]) begin
         n_checks++;
         n_err++;
         $display("FAIL scoreboard leftover d%0d due %0d: got no comparison, required one by cycle %0d",
                  sb[i].dut, sb[i].due, cyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
